// File: rtl/nts_rx_buffer.sv
// NTS receive buffer: drains one frame from the dispatcher FIFO into local RAM,
// classifies it as IPv4/UDP/NTP and holds accepted frames for the engine parser.
module nts_rx_buffer #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [15:0] NTP_PORT       = 16'd123
) (
    input  logic                  i_clk,
    input  logic                  i_areset_n,
    input  logic                  i_dispatch_packet_available,
    output logic                  o_dispatch_packet_read_discard,
    input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
    input  logic [7:0]            i_dispatch_data_valid,
    input  logic                  i_dispatch_fifo_empty,
    output logic                  o_dispatch_fifo_rd_start,
    input  logic                  i_dispatch_fifo_rd_valid,
    input  logic [63:0]           i_dispatch_fifo_rd_data,
    output logic                  o_busy,
    output logic                  o_packet_ready,
    output logic [ADDR_WIDTH-1:0] o_word_count,
    output logic [7:0]            o_last_data_valid,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [63:0]           o_rd_data,
    input  logic                  i_packet_done,
    output logic [31:0]           o_drop_count,
    output logic [31:0]           o_abort_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RECEIVE,
        S_CLASSIFY,
        S_DISCARD,
        S_READY
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [ADDR_WIDTH-1:0] counter_reg;
    logic [7:0]            dv_reg;
    logic [TW-1:0]         timer_reg;
    logic                  start_pulse_reg;
    logic                  accept_reg;
    logic [15:0]           ethertype_reg;
    logic [7:0]            ver_ihl_reg;
    logic [7:0]            proto_reg;
    logic [15:0]           port_reg;
    logic [31:0]           drop_count_reg;
    logic [31:0]           abort_count_reg;
    logic [63:0]           mem [DEPTH];
    logic [63:0]           rd_data_reg;

    logic capturing;
    logic wr_en;
    logic last_word;
    logic timeout;
    logic accept_now;
    logic unused_fifo_empty;

    // FIFO empty is informational only; readout is paced by rd_valid.
    assign unused_fifo_empty = i_dispatch_fifo_empty;

    assign capturing  = (state_reg == S_START) || (state_reg == S_RECEIVE);
    assign wr_en      = capturing && i_dispatch_fifo_rd_valid;
    assign last_word  = wr_en && (waddr_reg == counter_reg);
    assign timeout    = capturing && !i_dispatch_fifo_rd_valid &&
                        (timer_reg == TW'(TIMEOUT_CYCLES - 1));
    assign accept_now = (counter_reg >= ADDR_WIDTH'(5)) &&
                        (ethertype_reg == 16'h0800) &&
                        (ver_ihl_reg == 8'h45) &&
                        (proto_reg == 8'h11) &&
                        (port_reg == NTP_PORT);

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_dispatch_packet_available) state_next = S_START;
            end
            S_START, S_RECEIVE: begin
                if (timeout)        state_next = S_DISCARD;
                else if (last_word) state_next = S_CLASSIFY;
                else if (wr_en)     state_next = S_RECEIVE;
            end
            S_CLASSIFY: state_next = S_DISCARD;
            S_DISCARD:  state_next = accept_reg ? S_READY : S_IDLE;
            S_READY: begin
                if (i_packet_done) state_next = S_IDLE;
            end
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            waddr_reg       <= '0;
            counter_reg     <= '0;
            dv_reg          <= '0;
            timer_reg       <= '0;
            start_pulse_reg <= 1'b0;
            accept_reg      <= 1'b0;
            ethertype_reg   <= '0;
            ver_ihl_reg     <= '0;
            proto_reg       <= '0;
            port_reg        <= '0;
            drop_count_reg  <= '0;
            abort_count_reg <= '0;
        end else begin
            start_pulse_reg <= (state_reg == S_IDLE) && i_dispatch_packet_available;

            if ((state_reg == S_IDLE) && i_dispatch_packet_available) begin
                counter_reg   <= i_dispatch_counter;
                dv_reg        <= i_dispatch_data_valid;
                waddr_reg     <= '0;
                timer_reg     <= '0;
                accept_reg    <= 1'b0;
                ethertype_reg <= '0;
                ver_ihl_reg   <= '0;
                proto_reg     <= '0;
                port_reg      <= '0;
            end

            if (wr_en) begin
                waddr_reg <= waddr_reg + 1'b1;
                timer_reg <= '0;
                // Header fields are snooped as the words stream past.
                if (waddr_reg == ADDR_WIDTH'(1)) begin
                    ethertype_reg <= i_dispatch_fifo_rd_data[31:16];
                    ver_ihl_reg   <= i_dispatch_fifo_rd_data[15:8];
                end
                if (waddr_reg == ADDR_WIDTH'(2)) proto_reg <= i_dispatch_fifo_rd_data[7:0];
                if (waddr_reg == ADDR_WIDTH'(4)) port_reg  <= i_dispatch_fifo_rd_data[31:16];
            end else if (capturing && !timeout) begin
                timer_reg <= timer_reg + 1'b1;
            end

            if (timeout && (abort_count_reg != 32'hFFFF_FFFF)) begin
                abort_count_reg <= abort_count_reg + 1'b1;
            end

            if (state_reg == S_CLASSIFY) begin
                accept_reg <= accept_now;
                if (!accept_now && (drop_count_reg != 32'hFFFF_FFFF)) begin
                    drop_count_reg <= drop_count_reg + 1'b1;
                end
            end
        end
    end

    // Plain RAM write port; kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[waddr_reg] <= i_dispatch_fifo_rd_data;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[i_rd_addr];
        end
    end

    assign o_dispatch_fifo_rd_start       = start_pulse_reg;
    assign o_dispatch_packet_read_discard = (state_reg == S_DISCARD);
    assign o_busy                         = (state_reg != S_IDLE);
    assign o_packet_ready                 = (state_reg == S_READY);
    assign o_word_count                   = counter_reg;
    assign o_last_data_valid              = dv_reg;
    assign o_rd_data                      = rd_data_reg;
    assign o_drop_count                   = drop_count_reg;
    assign o_abort_count                  = abort_count_reg;

endmodule
